// File: rtl/match_event_tracker.sv
`default_nettype none
// ============================================================================
// match_event_tracker : counts rising edges of an upstream match and flags
//                       bursts of closely spaced events.
// Revision 1.0
// ============================================================================
module match_event_tracker #(
    parameter int BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       match_in,
    input  logic       clr,
    input  logic [3:0] thr,
    input  logic [1:0] sel,
    output logic [7:0] data_out,
    output logic       event_pulse,
    output logic       alert
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARMED   = 2'b01,
        S_BURST   = 2'b10,
        S_ILLEGAL = 2'b11
    } state_t;

    localparam logic [2:0] C_RUN_TOP = 3'(BURST_LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] event_cnt_q, event_cnt_d;
    logic [7:0] timer_q, timer_d;
    logic [7:0] last_gap_q, last_gap_d;
    logic [2:0] run_q, run_d;
    logic       cnt_sat_q, cnt_sat_d;
    logic       match_q, match_d;
    logic       event_pulse_q, event_pulse_d;

    logic       w_event;
    logic [7:0] w_gap;
    logic [8:0] w_timer_inc;
    logic [7:0] w_thr_ext;
    logic       w_qualify;
    logic       w_timeout;
    logic [2:0] w_run_inc;

    assign w_event     = ena & ~clr & match_in & ~match_q;
    assign w_timer_inc = {1'b0, timer_q} + 9'd1;
    assign w_gap       = (timer_q == 8'hFF) ? 8'hFF : timer_q + 8'd1;
    assign w_thr_ext   = {4'b0000, thr};
    assign w_qualify   = (w_gap <= w_thr_ext);
    // Once timer+1 reaches thr, the next event's gap would exceed thr.
    assign w_timeout   = (w_timer_inc >= {1'b0, w_thr_ext});
    assign w_run_inc   = run_q + 3'd1;

    always_comb begin
        state_d       = state_q;
        event_cnt_d   = event_cnt_q;
        timer_d       = timer_q;
        last_gap_d    = last_gap_q;
        run_d         = run_q;
        cnt_sat_d     = cnt_sat_q;
        match_d       = match_q;
        event_pulse_d = event_pulse_q;

        if (clr) begin
            state_d       = S_IDLE;
            event_cnt_d   = 8'd0;
            timer_d       = 8'd0;
            last_gap_d    = 8'd0;
            run_d         = 3'd0;
            cnt_sat_d     = 1'b0;
            match_d       = match_in;
            event_pulse_d = 1'b0;
        end else if (ena) begin
            match_d       = match_in;
            event_pulse_d = w_event;

            if (w_event) begin
                timer_d = 8'd0;
                if (event_cnt_q == 8'hFF) begin
                    cnt_sat_d = 1'b1;
                end else begin
                    event_cnt_d = event_cnt_q + 8'd1;
                end
            end else if (timer_q != 8'hFF) begin
                timer_d = timer_q + 8'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (w_event) begin
                        state_d = S_ARMED;
                    end
                end
                S_ARMED, S_BURST: begin
                    if (w_event) begin
                        last_gap_d = w_gap;
                        if (!w_qualify) begin
                            run_d   = 3'd0;
                            state_d = S_ARMED;
                        end else if (state_q == S_BURST) begin
                            run_d = C_RUN_TOP;
                        end else begin
                            run_d = w_run_inc;
                            if (w_run_inc == C_RUN_TOP) begin
                                state_d = S_BURST;
                            end
                        end
                    end else if (w_timeout) begin
                        run_d   = 3'd0;
                        state_d = S_ARMED;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            event_cnt_q   <= 8'd0;
            timer_q       <= 8'd0;
            last_gap_q    <= 8'd0;
            run_q         <= 3'd0;
            cnt_sat_q     <= 1'b0;
            match_q       <= 1'b0;
            event_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            event_cnt_q   <= event_cnt_d;
            timer_q       <= timer_d;
            last_gap_q    <= last_gap_d;
            run_q         <= run_d;
            cnt_sat_q     <= cnt_sat_d;
            match_q       <= match_d;
            event_pulse_q <= event_pulse_d;
        end
    end

    assign alert       = (state_q == S_BURST);
    assign event_pulse = event_pulse_q;

    always_comb begin
        data_out = 8'd0;
        case (sel)
            2'b00:   data_out = event_cnt_q;
            2'b01:   data_out = last_gap_q;
            2'b10:   data_out = timer_q;
            default: data_out = {state_q, run_q, cnt_sat_q, alert, 1'b0};
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_match_event_tracker.sv
`default_nettype none
// ============================================================================
// tb_match_event_tracker : directed self-checking bench for match_event_tracker.
// Revision 1.0
// ============================================================================
module tb_match_event_tracker;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       match_in;
    logic       clr;
    logic [3:0] thr;
    logic [1:0] sel;
    logic [7:0] data_out;
    logic       event_pulse;
    logic       alert;

    int checks = 0;
    int errors = 0;

    match_event_tracker #(.BURST_LEN(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .match_in    (match_in),
        .clr         (clr),
        .thr         (thr),
        .sel         (sel),
        .data_out    (data_out),
        .event_pulse (event_pulse),
        .alert       (alert)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] s, input logic [7:0] expv, input string tag);
        sel = s;
        #1;
        chk(tag, data_out, expv);
    endtask

    // One-cycle match pulse: the event is sampled on this edge.
    task automatic ev();
        match_in = 1'b1;
        step();
        match_in = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; match_in = 1'b0; clr = 1'b0; thr = 4'd4; sel = 2'b00;
        step(); step();
        chk("rst_alert", {7'd0, alert}, 8'd0);
        chk("rst_pulse", {7'd0, event_pulse}, 8'd0);
        rd(2'b00, 8'h00, "rst_cnt");
        rd(2'b11, 8'h00, "rst_status");
        rst_n = 1'b1; ena = 1'b1;
        step();

        // Two pulses three cycles apart
        ev();
        chk("sp_pulse1", {7'd0, event_pulse}, 8'd1);
        step();
        chk("sp_pulse1_off", {7'd0, event_pulse}, 8'd0);
        step();
        ev();
        chk("sp_pulse2", {7'd0, event_pulse}, 8'd1);
        rd(2'b00, 8'd2, "sp_cnt");
        rd(2'b01, 8'd3, "sp_gap");
        rd(2'b11, 8'h48, "sp_status");

        // Burst entry at the fourth gap-3 event, timeout exit 4 cycles later
        do_clr();
        rd(2'b00, 8'd0, "clr_cnt");
        rd(2'b11, 8'h00, "clr_status");
        thr = 4'd4;
        ev(); step(); step();
        ev(); step(); step();
        ev(); step(); step();
        chk("bu_pre_alert", {7'd0, alert}, 8'd0);
        ev();
        chk("bu_alert_rise", {7'd0, alert}, 8'd1);
        rd(2'b11, 8'h9A, "bu_status");
        rd(2'b00, 8'd4, "bu_cnt");
        step(); step(); step();
        chk("bu_alert_hold", {7'd0, alert}, 8'd1);
        step();
        chk("bu_alert_fall", {7'd0, alert}, 8'd0);
        rd(2'b11, 8'h40, "bu_exit_status");

        // Gap equal to thr qualifies
        do_clr();
        thr = 4'd2;
        ev(); step(); ev(); step(); ev(); step(); ev();
        chk("thr2_alert", {7'd0, alert}, 8'd1);
        rd(2'b01, 8'd2, "thr2_gap");

        // thr=1: minimum gap of 2 never qualifies
        do_clr();
        thr = 4'd1;
        ev(); step(); ev(); step(); ev(); step(); ev();
        chk("thr1_alert", {7'd0, alert}, 8'd0);
        rd(2'b01, 8'd2, "thr1_gap");
        rd(2'b11, 8'h40, "thr1_status");

        // Saturation
        do_clr();
        thr = 4'd0;
        for (int i = 0; i < 300; i++) begin
            ev();
            step();
        end
        rd(2'b00, 8'd255, "sat_cnt");
        rd(2'b11, 8'h44, "sat_status");
        repeat (400) step();
        rd(2'b10, 8'd255, "sat_timer");
        ev();
        rd(2'b01, 8'd255, "sat_gap");
        rd(2'b10, 8'd0, "sat_timer_reload");

        // Level held high, then clear on a new rising edge
        do_clr();
        thr = 4'd4;
        match_in = 1'b1;
        repeat (5) step();
        rd(2'b00, 8'd1, "lvl_cnt");
        match_in = 1'b0;
        step();
        match_in = 1'b1; clr = 1'b1;
        step();
        clr = 1'b0;
        chk("lvl_clr_pulse", {7'd0, event_pulse}, 8'd0);
        rd(2'b00, 8'd0, "lvl_clr_cnt");
        rd(2'b11, 8'h00, "lvl_clr_status");
        step(); step(); step();
        rd(2'b00, 8'd0, "lvl_no_event");
        chk("lvl_no_pulse", {7'd0, event_pulse}, 8'd0);
        match_in = 1'b0;
        step();

        // Enable low freezes everything; clear still works with ena low
        do_clr();
        ev(); step();
        ena = 1'b0;
        for (int i = 0; i < 20; i++) begin
            match_in = i[0];
            step();
        end
        match_in = 1'b0;
        rd(2'b00, 8'd1, "ena_cnt");
        rd(2'b01, 8'd0, "ena_gap");
        rd(2'b10, 8'd1, "ena_timer");
        rd(2'b11, 8'h40, "ena_status");
        clr = 1'b1;
        step();
        clr = 1'b0;
        rd(2'b00, 8'd0, "ena0_clr_cnt");
        rd(2'b11, 8'h00, "ena0_clr_status");
        ena = 1'b1;

        // Asynchronous reset while in BURST
        thr = 4'd2;
        ev(); step(); ev(); step(); ev(); step(); ev();
        chk("rb_alert", {7'd0, alert}, 8'd1);
        rst_n = 1'b0;
        #1;
        chk("rb_alert_off", {7'd0, alert}, 8'd0);
        chk("rb_pulse_off", {7'd0, event_pulse}, 8'd0);
        rd(2'b00, 8'd0, "rb_cnt");
        rd(2'b01, 8'd0, "rb_gap");
        rd(2'b10, 8'd0, "rb_timer");
        rd(2'b11, 8'd0, "rb_status");
        step();
        rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
